// File: rtl/dsm_dac_sample_sequencer.sv
// Sample sequencer feeding a 2nd-order delta-sigma modulator: input FIFO, clk_en divider, OSR hold, underrun zero-fill.
// Define DSM_SEQ_UNDERRUN_COUNT_EN for a saturating underrun counter; s_ready is !full of the registered level.
module dsm_dac_sample_sequencer #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4,
  parameter int OSR        = 64,
  parameter int PRELOAD    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [WIDTH-1:0]            s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [WIDTH-1:0]            dsm_in,
  output logic                        clk_en,
  output logic                        sample_tick,
  output logic                        underrun,
  output logic                        running,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef DSM_SEQ_UNDERRUN_COUNT_EN
  ,
  input  logic                        clr_count,
  output logic [15:0]                 underrun_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OW = $clog2(OSR);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    UNDR
  } state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    div_cnt, div_nxt;
  logic [OW-1:0]    osr_cnt, osr_nxt;
  logic [WIDTH-1:0] dsm_nxt;
  logic             clk_en_nxt, tick_nxt, urun_nxt;
  logic             push, pop, boundary;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] head;

  // Acceptance looks only at the registered level, so a same-cycle pop never frees a slot.
  assign s_ready  = (fifo_level != LW'(FIFO_DEPTH));
  assign push     = s_valid && s_ready;
  assign head     = mem[rd_ptr];
  assign running  = (state != IDLE);
  assign boundary = clk_en && (osr_cnt == OW'(OSR - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = '0;
    osr_nxt   = '0;
    dsm_nxt   = dsm_in;
    tick_nxt  = 1'b0;
    urun_nxt  = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        dsm_nxt = '0;
        if (enable && (fifo_level >= LW'(PRELOAD))) begin
          state_nxt = RUN;
          dsm_nxt   = head;
          pop       = 1'b1;
          tick_nxt  = 1'b1;
        end
      end
      default: begin
        if (!enable) begin
          // Disable wins over a coinciding boundary; the partial sample is dropped.
          state_nxt = IDLE;
          dsm_nxt   = '0;
        end else begin
          div_nxt = (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + DW'(1);
          osr_nxt = osr_cnt;
          if (clk_en) osr_nxt = (osr_cnt == OW'(OSR - 1)) ? '0 : osr_cnt + OW'(1);
          if (boundary) begin
            if (state == RUN) begin
              if (fifo_level != '0) begin
                dsm_nxt  = head;
                pop      = 1'b1;
                tick_nxt = 1'b1;
              end else begin
                dsm_nxt   = '0;
                urun_nxt  = 1'b1;
                tick_nxt  = 1'b1;
                state_nxt = UNDR;
              end
            end else if (fifo_level >= LW'(PRELOAD)) begin
              dsm_nxt   = head;
              pop       = 1'b1;
              tick_nxt  = 1'b1;
              state_nxt = RUN;
            end
          end
        end
      end
    endcase
    // Registered strobe mirrors div_cnt == CLK_DIV-1 of the upcoming cycle.
    clk_en_nxt = (state_nxt != IDLE) && (div_nxt == DW'(CLK_DIV - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      osr_cnt     <= '0;
      clk_en      <= 1'b0;
      dsm_in      <= '0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_nxt;
      div_cnt     <= div_nxt;
      osr_cnt     <= osr_nxt;
      clk_en      <= clk_en_nxt;
      dsm_in      <= dsm_nxt;
      sample_tick <= tick_nxt;
      underrun    <= urun_nxt;
    end
  end

`ifdef DSM_SEQ_UNDERRUN_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_count <= '0;
    end else if (clr_count) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dsm_dac_sample_sequencer.sv
// Bench for dsm_dac_sample_sequencer: two instances (CLK_DIV=4/OSR=4 and CLK_DIV=1/OSR=2) against a queue-based model.
module tb_dsm_dac_sample_sequencer;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int PRE   = 2;
  localparam int LW    = 3;

  logic clk = 1'b0;
  logic rst;
  logic en [2];
  logic sv [2];
  logic [W-1:0] sd [2];
`ifdef DSM_SEQ_UNDERRUN_COUNT_EN
  logic clr [2];
  logic [15:0] a_cnt, b_cnt;
`endif

  logic [W-1:0]  a_dsm, b_dsm;
  logic          a_ce, a_tk, a_ur, a_rn, a_rdy;
  logic          b_ce, b_tk, b_ur, b_rn, b_rdy;
  logic [LW-1:0] a_lvl, b_lvl;

  always #5 clk = ~clk;

  dsm_dac_sample_sequencer #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .CLK_DIV(4), .OSR(4), .PRELOAD(PRE)) u_a (
    .clk(clk), .rst(rst), .enable(en[0]), .s_data(sd[0]), .s_valid(sv[0]), .s_ready(a_rdy),
    .dsm_in(a_dsm), .clk_en(a_ce), .sample_tick(a_tk), .underrun(a_ur), .running(a_rn), .fifo_level(a_lvl)
`ifdef DSM_SEQ_UNDERRUN_COUNT_EN
    , .clr_count(clr[0]), .underrun_count(a_cnt)
`endif
  );

  dsm_dac_sample_sequencer #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .CLK_DIV(1), .OSR(2), .PRELOAD(PRE)) u_b (
    .clk(clk), .rst(rst), .enable(en[1]), .s_data(sd[1]), .s_valid(sv[1]), .s_ready(b_rdy),
    .dsm_in(b_dsm), .clk_en(b_ce), .sample_tick(b_tk), .underrun(b_ur), .running(b_rn), .fifo_level(b_lvl)
`ifdef DSM_SEQ_UNDERRUN_COUNT_EN
    , .clr_count(clr[1]), .underrun_count(b_cnt)
`endif
  );

  // Model: FIFO as a queue, time since run start as a plain cycle number.
  logic [W-1:0] mq [2][$];
  bit           m_run [2];
  bit           m_und [2];
  int           m_t [2];
  logic [W-1:0] m_dsm [2];
  bit           m_tick [2];
  bit           m_urun [2];
  int           m_cnt [2];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int cdv(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int osrv(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic bit m_clk_en(input int i);
    return m_run[i] && (((m_t[i] + 1) % cdv(i)) == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_run[i]  = 0;
      m_und[i]  = 0;
      m_t[i]    = 0;
      m_dsm[i]  = '0;
      m_tick[i] = 0;
      m_urun[i] = 0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic model_step();
    int lvl;
    bit push, bnd, tick, urun;
    for (int i = 0; i < 2; i++) begin
      lvl  = mq[i].size();
      push = sv[i] && (lvl < DEPTH);
      bnd  = m_clk_en(i) && ((((m_t[i] + 1) / cdv(i)) % osrv(i)) == 0);
      tick = 0;
      urun = 0;
`ifdef DSM_SEQ_UNDERRUN_COUNT_EN
      if (clr[i]) m_cnt[i] = 0;
      else if (m_urun[i] && m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
`endif
      if (!m_run[i]) begin
        m_dsm[i] = '0;
        if (en[i] && lvl >= PRE) begin
          m_dsm[i] = mq[i].pop_front();
          tick = 1;
          m_run[i] = 1;
          m_und[i] = 0;
          m_t[i] = 0;
        end
      end else if (!en[i]) begin
        m_run[i] = 0;
        m_dsm[i] = '0;
      end else begin
        if (bnd && !m_und[i]) begin
          if (lvl > 0) begin
            m_dsm[i] = mq[i].pop_front();
            tick = 1;
          end else begin
            m_dsm[i] = '0;
            urun = 1;
            tick = 1;
            m_und[i] = 1;
          end
        end else if (bnd && lvl >= PRE) begin
          m_dsm[i] = mq[i].pop_front();
          tick = 1;
          m_und[i] = 0;
        end
        m_t[i] = m_t[i] + 1;
      end
      if (push) mq[i].push_back(sd[i]);
      m_tick[i] = tick;
      m_urun[i] = urun;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input logic [W-1:0] dsm, input logic ce, input logic tk,
                            input logic ur, input logic rn, input logic rdy, input logic [LW-1:0] lvl);
    chk($sformatf("dsm_in[%0d]", i),      int'(dsm), int'(m_dsm[i]));
    chk($sformatf("clk_en[%0d]", i),      int'(ce),  int'(m_clk_en(i)));
    chk($sformatf("sample_tick[%0d]", i), int'(tk),  int'(m_tick[i]));
    chk($sformatf("underrun[%0d]", i),    int'(ur),  int'(m_urun[i]));
    chk($sformatf("running[%0d]", i),     int'(rn),  int'(m_run[i]));
    chk($sformatf("s_ready[%0d]", i),     int'(rdy), int'(mq[i].size() < DEPTH));
    chk($sformatf("fifo_level[%0d]", i),  int'(lvl), mq[i].size());
  endtask

  task automatic compare();
    check_inst(0, a_dsm, a_ce, a_tk, a_ur, a_rn, a_rdy, a_lvl);
    check_inst(1, b_dsm, b_ce, b_tk, b_ur, b_rn, b_rdy, b_lvl);
`ifdef DSM_SEQ_UNDERRUN_COUNT_EN
    chk("underrun_count[0]", int'(a_cnt), m_cnt[0]);
    chk("underrun_count[1]", int'(b_cnt), m_cnt[1]);
`endif
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic reset_lits(input string tag);
    chk({tag, "_dsm"},     int'(a_dsm), 0);
    chk({tag, "_clk_en"},  int'(a_ce),  0);
    chk({tag, "_tick"},    int'(a_tk),  0);
    chk({tag, "_under"},   int'(a_ur),  0);
    chk({tag, "_running"}, int'(a_rn),  0);
    chk({tag, "_ready"},   int'(a_rdy), 1);
    chk({tag, "_level"},   int'(a_lvl), 0);
    chk({tag, "_b_level"}, int'(b_lvl), 0);
  endtask

  initial begin
    int n, nce, ntk, nur, thr;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0;
      sv[i] = 1'b0;
      sd[i] = '0;
`ifdef DSM_SEQ_UNDERRUN_COUNT_EN
      clr[i] = 1'b0;
`endif
    end
    model_reset();
    cyc(2);
    reset_lits("reset");
    rst = 1'b0;
    cyc(1);

    // Preload two words in IDLE, then start.
    sv[0] = 1'b1; sd[0] = 16'h1000; cyc(1);
    sd[0] = 16'h2000; cyc(1);
    sv[0] = 1'b0;
    chk("preload_level", int'(a_lvl), 2);
    chk("preload_idle_clk_en", int'(a_ce), 0);
    en[0] = 1'b1; cyc(1);
    chk("entry_dsm", int'(a_dsm), 16'h1000);
    chk("entry_tick", int'(a_tk), 1);
    n = 0; nce = 0;
    while (a_dsm == 16'h1000 && n < 100) begin nce += int'(a_ce); cyc(1); n++; end
    chk("first_sample_cycles", n, 16);
    chk("first_sample_strobes", nce, 4);
    chk("second_dsm", int'(a_dsm), 16'h2000);
    chk("second_tick", int'(a_tk), 1);

    // Drain to underrun, then refill two words and resume.
    n = 0;
    while (a_ur == 1'b0 && n < 100) begin cyc(1); n++; end
    chk("underrun_after", n, 16);
    chk("underrun_dsm", int'(a_dsm), 0);
    chk("underrun_tick", int'(a_tk), 1);
    sv[0] = 1'b1; sd[0] = 16'h3000; cyc(1);
    sd[0] = 16'h4000; cyc(1);
    sv[0] = 1'b0;
    n = 0; nce = 0; nur = 0;
    while (a_dsm == 16'h0000 && n < 100) begin nce += int'(a_ce); nur += int'(a_ur); cyc(1); n++; end
    chk("resume_cycles", n, 14);
    chk("underrun_strobes", nce, 4);
    chk("no_second_underrun", nur, 0);
    chk("resume_dsm", int'(a_dsm), 16'h3000);

    // Disable while osr_cnt is 2, then re-enable.
    cyc(8);
    en[0] = 1'b0; cyc(1);
    chk("disable_dsm", int'(a_dsm), 0);
    chk("disable_clk_en", int'(a_ce), 0);
    chk("disable_running", int'(a_rn), 0);
    chk("disable_level", int'(a_lvl), 1);
    sv[0] = 1'b1; sd[0] = 16'h5555; cyc(1);
    sv[0] = 1'b0;
    en[0] = 1'b1; cyc(1);
    chk("reenable_dsm", int'(a_dsm), 16'h4000);

    // Asynchronous reset between edges while running.
    cyc(5);
    #2 rst = 1'b1;
    #1 model_reset();
    reset_lits("async_reset");
    compare();
    en[0] = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Backpressure: five words offered with s_valid held.
    sv[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin sd[0] = 16'hA100 + 16'(k); cyc(1); end
    chk("full_ready", int'(a_rdy), 0);
    chk("full_level", int'(a_lvl), 4);
    sd[0] = 16'hA104; cyc(3);
    chk("full_hold_level", int'(a_lvl), 4);
    en[0] = 1'b1; cyc(1);
    chk("pop_level", int'(a_lvl), 3);
    chk("pop_dsm", int'(a_dsm), 16'hA100);
    cyc(1);
    chk("fifth_accepted_level", int'(a_lvl), 4);
    sv[0] = 1'b0;
    en[0] = 1'b0; cyc(1);

    // CLK_DIV=1, OSR=2 instance.
    sv[1] = 1'b1; sd[1] = 16'hB000; cyc(1);
    sd[1] = 16'hB001; cyc(1);
    sv[1] = 1'b0;
    en[1] = 1'b1; cyc(1);
    chk("b_entry_dsm", int'(b_dsm), 16'hB000);
    nce = 0; ntk = 0;
    for (int k = 0; k < 4; k++) begin nce += int'(b_ce); ntk += int'(b_tk); cyc(1); end
    chk("b_strobes", nce, 4);
    chk("b_ticks", ntk, 2);
    chk("b_underrun1", int'(b_ur), 1);
    for (int r = 0; r < 2; r++) begin
      sv[1] = 1'b1; sd[1] = 16'hC000 + 16'(r); cyc(1);
      sd[1] = 16'hD000 + 16'(r); cyc(1);
      sv[1] = 1'b0;
      n = 0;
      while (b_ur == 1'b0 && n < 50) begin cyc(1); n++; end
      chk("b_underrun_seen", int'(b_ur), 1);
    end
    cyc(1);
`ifdef DSM_SEQ_UNDERRUN_COUNT_EN
    chk("b_underrun_count3", int'(b_cnt), 3);
`endif
    sv[1] = 1'b1; sd[1] = 16'hE000; cyc(1);
    sd[1] = 16'hE001; cyc(1);
    sv[1] = 1'b0;
    n = 0;
    while (b_ur == 1'b0 && n < 50) begin cyc(1); n++; end
    chk("b_underrun4_seen", int'(b_ur), 1);
`ifdef DSM_SEQ_UNDERRUN_COUNT_EN
    clr[1] = 1'b1; cyc(1);
    clr[1] = 1'b0;
    chk("b_clr_coincident", int'(b_cnt), 0);
`else
    cyc(1);
`endif

    // Randomized traffic on both instances.
    en[0] = 1'b1; en[1] = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) thr = $urandom_range(1, 12);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 63) == 0) en[i] = ~en[i];
        sv[i] = ($urandom_range(0, 15) < thr);
        sd[i] = 16'($urandom());
`ifdef DSM_SEQ_UNDERRUN_COUNT_EN
        clr[i] = ($urandom_range(0, 99) == 0);
`endif
      end
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
